io_rx_controller: RTL and testbench

Receives a raster-ordered stream of 8-bit pixels over a valid/ready handshake and writes each pixel into image SRAM at its (row, col) address. It is the write-side counterpart of the SRAM readout path. It loads an image into the SRAM before convolution: one frame per `en` pulse, one pixel per cycle at full throughput.

---
 rtl/io_ctrl_pkg.sv | 20 ++
 rtl/img_sram_intf.sv | 46 ++++
 rtl/io_rx_controller.sv | 155 +++++++++++++++
 tb/tb_io_rx_controller.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// io_ctrl_pkg
// Shared definitions for the image SRAM I/O controllers (the receive/write
// side and the readout side).
//   IMG_DIM_W  : default width of row/col indices and frame size inputs
//   IMG_PIX_W  : default pixel width
//   rx_state_t : receive controller state encoding
// ---------------------------------------------------------------------------
package io_ctrl_pkg;

    localparam int IMG_DIM_W = 8;
    localparam int IMG_PIX_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        FLUSH = 2'd2
    } rx_state_t;

endpackage : io_ctrl_pkg

// File: rtl/img_sram_intf.sv
// ---------------------------------------------------------------------------
// img_sram_intf
// Port bundle of the image SRAM.
//   clk      : SRAM clock (shared with the controllers)
//   write_en : write strobe, one pixel per cycle
//   sense_en : read strobe
//   row/col  : pixel address
//   din      : write data
//   dout     : read data
// The mst modport is the controller side; slv is the SRAM macro side.
// ---------------------------------------------------------------------------
interface img_sram_intf #(
    parameter int DIM_W = io_ctrl_pkg::IMG_DIM_W,
    parameter int PIX_W = io_ctrl_pkg::IMG_PIX_W
) (
    input logic clk
);

    logic             write_en;
    logic             sense_en;
    logic [DIM_W-1:0] row;
    logic [DIM_W-1:0] col;
    logic [PIX_W-1:0] din;
    logic [PIX_W-1:0] dout;

    modport mst (
        input  clk,
        output write_en,
        output sense_en,
        output row,
        output col,
        output din,
        input  dout
    );

    modport slv (
        input  clk,
        input  write_en,
        input  sense_en,
        input  row,
        input  col,
        input  din,
        output dout
    );

endinterface : img_sram_intf

// File: rtl/io_rx_controller.sv
// ---------------------------------------------------------------------------
// io_rx_controller
// Loads one raster-ordered frame of pixels into the image SRAM per `en`
// pulse, one pixel per cycle, writing each pixel at its (row, col) address.
//   clk, rst    : clock, synchronous active-high reset
//   en          : frame start request (sampled in IDLE only)
//   abort       : terminate the current frame (sampled in RECV/FLUSH)
//   nrows/ncols : last row/column index, inclusive; latched at frame start
//   din/din_valid/din_ready : pixel stream handshake
//   busy        : frame in progress
//   done        : one-cycle pulse on normal frame completion
//   sram_img    : SRAM write port (read side unused, sense_en tied low)
// ---------------------------------------------------------------------------
module io_rx_controller
    import io_ctrl_pkg::*;
#(
    parameter int DIM_W = IMG_DIM_W,
    parameter int PIX_W = IMG_PIX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             abort,
    input  logic [DIM_W-1:0] nrows,
    input  logic [DIM_W-1:0] ncols,
    input  logic [PIX_W-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             busy,
    output logic             done,
    img_sram_intf.mst        sram_img
);

    rx_state_t        state_q,    state_d;
    logic [DIM_W-1:0] last_row_q, last_row_d;
    logic [DIM_W-1:0] last_col_q, last_col_d;
    logic [DIM_W-1:0] row_idx_q,  row_idx_d;
    logic [DIM_W-1:0] col_idx_q,  col_idx_d;
    logic             done_q,     done_d;

    // Write stage: holds the address/data of the previous cycle's transfer.
    logic             wr_en_q,    wr_en_d;
    logic [DIM_W-1:0] wr_row_q,   wr_row_d;
    logic [DIM_W-1:0] wr_col_q,   wr_col_d;
    logic [PIX_W-1:0] wr_data_q,  wr_data_d;

    logic xfer;
    logic last_col_hit;
    logic last_pix_hit;

    // Ready depends on state only, so there is no din_valid -> din_ready path.
    assign din_ready    = (state_q == RECV);
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign xfer         = din_ready & din_valid;
    assign last_col_hit = (col_idx_q == last_col_q);
    assign last_pix_hit = last_col_hit & (row_idx_q == last_row_q);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave it unassigned and infer a latch.
        state_d    = state_q;
        last_row_d = last_row_q;
        last_col_d = last_col_q;
        row_idx_d  = row_idx_q;
        col_idx_d  = col_idx_q;
        done_d     = 1'b0;
        wr_en_d    = 1'b0;
        wr_row_d   = wr_row_q;
        wr_col_d   = wr_col_q;
        wr_data_d  = wr_data_q;

        unique case (state_q)
            IDLE: begin
                // en takes priority; abort is not sampled here.
                if (en) begin
                    last_row_d = nrows;
                    last_col_d = ncols;
                    row_idx_d  = '0;
                    col_idx_d  = '0;
                    state_d    = RECV;
                end
            end

            RECV: begin
                if (xfer) begin
                    wr_en_d   = 1'b1;
                    wr_row_d  = row_idx_q;
                    wr_col_d  = col_idx_q;
                    wr_data_d = din;
                    // After the last pixel the row index steps past last_row;
                    // that value is never used and is cleared at the next start.
                    if (last_col_hit) begin
                        col_idx_d = '0;
                        row_idx_d = row_idx_q + 1'b1;
                    end else begin
                        col_idx_d = col_idx_q + 1'b1;
                    end
                    if (last_pix_hit) begin
                        state_d = FLUSH;
                    end
                end
                // A transfer in the abort cycle is still written above.
                if (abort) begin
                    state_d = IDLE;
                end
            end

            FLUSH: begin
                // The final write is on the SRAM port during this cycle.
                state_d = IDLE;
                done_d  = ~abort;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q    <= IDLE;
            last_row_q <= '0;
            last_col_q <= '0;
            row_idx_q  <= '0;
            col_idx_q  <= '0;
            done_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_row_q   <= '0;
            wr_col_q   <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_row_q <= last_row_d;
            last_col_q <= last_col_d;
            row_idx_q  <= row_idx_d;
            col_idx_q  <= col_idx_d;
            done_q     <= done_d;
            wr_en_q    <= wr_en_d;
            wr_row_q   <= wr_row_d;
            wr_col_q   <= wr_col_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign sram_img.write_en = wr_en_q;
    assign sram_img.sense_en = 1'b0;
    assign sram_img.row      = wr_row_q;
    assign sram_img.col      = wr_col_q;
    assign sram_img.din      = wr_data_q;

endmodule : io_rx_controller

// File: tb/tb_io_rx_controller.sv
// ---------------------------------------------------------------------------
// tb_io_rx_controller
// Directed frames are driven into io_rx_controller; each accepted pixel
// pushes its expected SRAM write onto a queue, and a monitor pops and
// compares whenever the SRAM port shows write_en.
// ---------------------------------------------------------------------------
module tb_io_rx_controller;

    typedef struct packed {
        logic [7:0] row;
        logic [7:0] col;
        logic [7:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       abort;
    logic [7:0] nrows;
    logic [7:0] ncols;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       busy;
    logic       done;

    int  n_tests   = 0;
    int  n_fail    = 0;
    int  cyc       = 0;
    int  start_cyc = 0;
    int  wr_cnt    = 0;
    int  done_cnt  = 0;
    logic [7:0] last_wr_row = '0;
    logic [7:0] last_wr_col = '0;
    wr_t exp_q[$];

    img_sram_intf #(.DIM_W(8), .PIX_W(8)) sram_if (.clk(clk));

    io_rx_controller #(.DIM_W(8), .PIX_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .abort     (abort),
        .nrows     (nrows),
        .ncols     (ncols),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .busy      (busy),
        .done      (done),
        .sram_img  (sram_if)
    );

    assign sram_if.dout = 8'h00;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: sample mid-cycle, away from the active edge.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (sram_if.write_en === 1'b1) begin
            wr_cnt++;
            last_wr_row = sram_if.row;
            last_wr_col = sram_if.col;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("wr_row",  sram_if.row, e.row);
                check("wr_col",  sram_if.col, e.col);
                check("wr_data", sram_if.din, e.data);
            end
            check("sense_en", sram_if.sense_en, 0);
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [7:0] nr, input logic [7:0] nc);
        en    = 1'b1;
        nrows = nr;
        ncols = nc;
        tick();
        en        = 1'b0;
        start_cyc = cyc;
        check("start_busy",  busy,      1);
        check("start_ready", din_ready, 1);
    endtask

    // Present one pixel with din_valid high for one edge; expect it written.
    task automatic send(input int r, input int c, input logic [7:0] d);
        din_valid = 1'b1;
        din       = d;
        exp_q.push_back('{row: 8'(r), col: 8'(c), data: d});
        tick();
    endtask

    task automatic bubble();
        din_valid = 1'b0;
        din       = 8'hEE;
        tick();
    endtask

    // Called right after the last-pixel edge: FLUSH now, done one cycle later.
    task automatic finish_frame(input int exp_dt);
        int dt;
        din_valid = 1'b0;
        check("flush_busy",  busy,             1);
        check("flush_ready", din_ready,        0);
        check("flush_done",  done,             0);
        check("flush_write", sram_if.write_en, 1);
        for (int i = 0; i < 4 && done !== 1'b1; i++) tick();
        check("done_seen", done, 1);
        dt = cyc - start_cyc;
        if (exp_dt >= 0) check("done_latency", dt, exp_dt);
        check("done_busy",  busy,          0);
        check("done_ready", din_ready,     0);
        check("queue_empty", exp_q.size(), 0);
        tick();
        check("done_pulse", done, 0);
    endtask

    task automatic run_frame(input int nr, input int nc, input logic [7:0] base,
                             input bit bubbles, input int exp_dt);
        int idx = 0;
        start_frame(8'(nr), 8'(nc));
        for (int r = 0; r <= nr; r++) begin
            for (int c = 0; c <= nc; c++) begin
                send(r, c, 8'(base + idx));
                idx++;
                if (bubbles && !(r == nr && c == nc)) bubble();
            end
        end
        finish_frame(exp_dt);
    endtask

    initial begin
        int d0, w0;
        rst = 1'b1; en = 1'b0; abort = 1'b0; nrows = '0; ncols = '0;
        din = '0; din_valid = 1'b0;
        tick(); tick();

        // Reset state.
        check("rst_ready",    din_ready,        0);
        check("rst_busy",     busy,             0);
        check("rst_done",     done,             0);
        check("rst_write_en", sram_if.write_en, 0);
        check("rst_sense_en", sram_if.sense_en, 0);
        check("rst_row",      sram_if.row,      0);
        check("rst_col",      sram_if.col,      0);
        check("rst_din",      sram_if.din,      0);
        rst = 1'b0;
        tick();
        check("idle_ready", din_ready, 0);

        // 2x3 frame at full rate: done 7 cycles after E0.
        run_frame(1, 2, 8'h10, 1'b0, 7);
        // Same frame with a bubble between pixels: 6 transfers over 11 edges.
        run_frame(1, 2, 8'h20, 1'b1, 12);
        // Single pixel.
        run_frame(0, 0, 8'hAB, 1'b0, 2);

        // Abort in FLUSH: pending write lands, done suppressed.
        d0 = done_cnt;
        start_frame(8'd0, 8'd0);
        send(0, 0, 8'hCD);
        din_valid = 1'b0;
        check("abflush_write", sram_if.write_en, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abflush_done", done, 0);
        check("abflush_busy", busy, 0);
        tick(); tick();
        check("abflush_no_done", done_cnt - d0, 0);
        check("abflush_queue", exp_q.size(), 0);

        // Abort at pixel 3 of a 4x4 frame.
        d0 = done_cnt;
        start_frame(8'd3, 8'd3);
        for (int c = 0; c < 3; c++) send(0, c, 8'(8'h30 + c));
        abort = 1'b1;
        send(0, 3, 8'h33);
        abort = 1'b0;
        din_valid = 1'b0;
        check("abort_busy",  busy,             0);
        check("abort_ready", din_ready,        0);
        check("abort_write", sram_if.write_en, 1);
        tick(); tick(); tick();
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_queue",   exp_q.size(),  0);
        run_frame(0, 1, 8'h40, 1'b0, 3);

        // abort with en in IDLE: en wins.
        en = 1'b1; abort = 1'b1; nrows = 8'd0; ncols = 8'd0;
        tick();
        en = 1'b0; abort = 1'b0; start_cyc = cyc;
        check("en_wins_busy", busy, 1);
        send(0, 0, 8'h5A);
        finish_frame(2);

        // en while busy and size change mid-frame: latched 3x3 governs.
        start_frame(8'd2, 8'd2);
        send(0, 0, 8'h60);
        en = 1'b1; nrows = 8'd0; ncols = 8'd0;
        send(0, 1, 8'h61);
        en = 1'b0;
        for (int i = 2; i < 9; i++) begin
            if (i == 8) check("midchg_still_busy", busy, 1);
            send(i / 3, i % 3, 8'(8'h60 + i));
        end
        finish_frame(10);

        // rst mid-frame with a pixel offered on the reset edge: not written.
        start_frame(8'd3, 8'd3);
        send(0, 0, 8'h70);
        send(0, 1, 8'h71);
        din_valid = 1'b1; din = 8'h77; rst = 1'b1;
        tick();
        rst = 1'b0; din_valid = 1'b0;
        check("mrst_write_en", sram_if.write_en, 0);
        check("mrst_busy",     busy,             0);
        check("mrst_ready",    din_ready,        0);
        check("mrst_done",     done,             0);
        check("mrst_row",      sram_if.row,      0);
        check("mrst_col",      sram_if.col,      0);
        check("mrst_din",      sram_if.din,      0);
        tick(); tick();
        check("mrst_queue", exp_q.size(), 0);

        // Full 256x256 frame.
        d0 = done_cnt;
        w0 = wr_cnt;
        run_frame(255, 255, 8'h00, 1'b0, 65537);
        tick();
        check("full_writes",   wr_cnt - w0,   65536);
        check("full_last_row", last_wr_row,   8'hFF);
        check("full_last_col", last_wr_col,   8'hFF);
        check("full_done_cnt", done_cnt - d0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_io_rx_controller
